// File: rtl/mem_req_master.sv
// Queued request master: buffers upstream read/write requests and issues them one at a time
// to a valid/ready memory port, holding each read response until the consumer takes it.
module mem_req_master #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic                            req_wr_rd_i,
    input  logic [ADDR_WIDTH-1:0]           req_addr_i,
    input  logic [WIDTH-1:0]                req_wdata_i,
    output logic                            mem_valid_o,
    input  logic                            mem_ready_i,
    output logic                            mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0]           mem_addr_o,
    output logic [WIDTH-1:0]                mem_wdata_o,
    input  logic [WIDTH-1:0]                mem_rdata_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [WIDTH-1:0]                rsp_rdata_o,
    output logic [$clog2(FIFO_DEPTH):0]     count_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    // Pointers wrap by natural overflow, so the queue depth must be a power of two.
    if ((FIFO_DEPTH < 2) || ((1 << PW) != FIFO_DEPTH) || (DEPTH > (1 << ADDR_WIDTH))) begin : g_param_check
        $error("mem_req_master: bad FIFO_DEPTH or DEPTH/ADDR_WIDTH combination");
    end

    typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

    state_t                  state_r, state_next_s;
    logic                    q_wr_r    [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   q_addr_r  [FIFO_DEPTH];
    logic [WIDTH-1:0]        q_wdata_r [FIFO_DEPTH];
    logic [PW-1:0]           wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]           count_r, count_next_s;
    logic                    ready_r, mem_valid_r, mem_wr_rd_r, rsp_valid_r;
    logic [ADDR_WIDTH-1:0]   mem_addr_r;
    logic [WIDTH-1:0]        mem_wdata_r, rsp_rdata_r;
    logic                    push_s, pop_s, hs_s, head_wr_s;

    assign push_s    = req_valid_i && ready_r;
    assign hs_s      = (state_r == ISSUE) && mem_ready_i;
    assign head_wr_s = q_wr_r[rd_ptr_r];

    // Next-state: a read waits at the head while an earlier response is still unconsumed.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if ((count_r != '0) && (head_wr_s || !rsp_valid_r)) begin
                    pop_s        = 1'b1;
                    state_next_s = ISSUE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ISSUE: begin
                if (mem_ready_i) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Occupancy update for push, pop or both in the same cycle.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FSM state, queue pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r  <= IDLE;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            ready_r  <= 1'b1;
        end else begin
            state_r  <= state_next_s;
            count_r  <= count_next_s;
            ready_r  <= (count_next_s < FULL_CNT);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // Queue storage written at the tail.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_wr_r[i]    <= 1'b0;
                q_addr_r[i]  <= '0;
                q_wdata_r[i] <= '0;
            end
        end else if (push_s) begin
            q_wr_r[wr_ptr_r]    <= req_wr_rd_i;
            q_addr_r[wr_ptr_r]  <= req_addr_i;
            q_wdata_r[wr_ptr_r] <= req_wdata_i;
        end
    end

    // Memory-side command registers, loaded from the head on pop and frozen during ISSUE.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mem_valid_r <= 1'b0;
            mem_wr_rd_r <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            mem_valid_r <= (state_next_s == ISSUE);
            if (pop_s) begin
                mem_wr_rd_r <= head_wr_s;
                mem_addr_r  <= q_addr_r[rd_ptr_r];
                mem_wdata_r <= q_wdata_r[rd_ptr_r];
            end
        end
    end

    // Read response holding register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
        end else if (hs_s && !mem_wr_rd_r) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= mem_rdata_i;
        end else if (rsp_ready_i) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign req_ready_o = ready_r;
    assign count_o     = count_r;
    assign mem_valid_o = mem_valid_r;
    assign mem_wr_rd_o = mem_wr_rd_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;

endmodule

// File: doc/mem_req_master.md
MEM_REQ_MASTER -- requirements
Module: mem_req_master

Interface
REQ-001 Parameter WIDTH, default 16, data width of memory words.
REQ-002 Parameter ADDR_WIDTH, default 4, address width.
REQ-003 Parameter DEPTH, default 16, number of memory words addressed by the downstream memory.
REQ-004 Parameter FIFO_DEPTH, default 4, request queue entries (power of two, >=2).
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_i  in  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  in  1  upstream request present.
REQ-008 req_ready_o  out  1  queue can accept a request.
REQ-009 req_wr_rd_i  in  1  1=write, 0=read.
REQ-010 req_addr_i  in  ADDR_WIDTH  request address.
REQ-011 req_wdata_i  in  WIDTH  write data; ignored for reads.
REQ-012 mem_valid_o  out  1  drives memory valid_i.
REQ-013 mem_ready_i  in  1  from memory ready_o.
REQ-014 mem_wr_rd_o  out  1  drives memory wr_rd_i.
REQ-015 mem_addr_o  out  ADDR_WIDTH  drives memory addr_i.
REQ-016 mem_wdata_o  out  WIDTH  drives memory wdata_i.
REQ-017 mem_rdata_i  in  WIDTH  from memory rdata_o; valid in the cycle mem_valid_o and mem_ready_i are both 1 for a read.
REQ-018 rsp_valid_o  out  1  read response held.
REQ-019 rsp_ready_i  in  1  consumer accepts response.
REQ-020 rsp_rdata_o  out  WIDTH  read response data.
REQ-021 count_o  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.

Function
REQ-022 Push occurs on an edge where req_valid_i=1 and req_ready_o=1; {wr_rd, addr, wdata} stored at tail, in order.
REQ-023 req_ready_o = (count_o < FIFO_DEPTH), registered occupancy only; a same-cycle pop does not allow a push into a full queue.
REQ-024 FSM states: IDLE, ISSUE.
REQ-025 IDLE: if queue non-empty and (head is write or rsp_valid_o=0), at next edge load head into mem_wr_rd_o/mem_addr_o/mem_wdata_o, pop head, go to ISSUE; otherwise stay IDLE.
REQ-026 ISSUE: mem_valid_o=1; mem_wr_rd_o, mem_addr_o, mem_wdata_o held stable until handshake (mem_valid_o=1 and mem_ready_i=1 at an edge).
REQ-027 On write handshake: go to IDLE; no response generated.
REQ-028 On read handshake: capture mem_rdata_i into rsp_rdata_o, set rsp_valid_o=1, go to IDLE.
REQ-029 mem_valid_o=0 in IDLE; at most one memory transaction outstanding; back-to-back transactions separated by at least one IDLE cycle.
REQ-030 Latency: push into empty queue at edge E, mem_ready_i tied 1 -> mem_valid_o high during cycle after E+1, handshake at E+2, read rsp_valid_o high after E+2.
REQ-031 rsp_valid_o and rsp_rdata_o held stable until an edge with rsp_ready_i=1; then rsp_valid_o=0.
REQ-032 Read at head while rsp_valid_o=1: head stalls in queue (no reordering past it) until response consumed.
REQ-033 Simultaneous push and pop: count_o unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-034 Push and pop update count_o in the same edge; count_o never exceeds FIFO_DEPTH nor underflows.

Reset
REQ-035 reset_i=0 immediately forces: state IDLE, queue emptied, count_o=0, req_ready_o=1 (once released), mem_valid_o=0, mem_wr_rd_o=0, mem_addr_o=0, mem_wdata_o=0, rsp_valid_o=0, rsp_rdata_o=0.
REQ-036 Reset mid-transaction drops the in-flight and all queued requests; no response is produced for them.
REQ-037 Release of reset_i takes effect at the first rising edge after deassertion; no request accepted before it.

Verification
REQ-038 Write addr 3 data 0x00A5, then read addr 3, mem_ready_i=1 -> one rsp with rsp_rdata_o=0x00A5, count_o returns to 0.
REQ-039 Push 4 requests with mem_ready_i=0 -> count_o reaches 3 or 4, req_ready_o=0 at count 4, mem outputs stable while waiting; then mem_ready_i=1 -> all 4 issued in push order.
REQ-040 Two reads (addr 1, 2) with rsp_ready_i=0 -> first rsp held, second read not issued (mem_valid_o=0) until rsp_ready_i=1, then second rsp returns addr-2 data.
REQ-041 Continuous push/pop at full occupancy over 3*FIFO_DEPTH requests -> pointer wrap-around, order preserved, no loss or duplication.
REQ-042 reset_i=0 while mem_valid_o=1 and 2 entries queued -> mem_valid_o=0 same cycle, count_o=0, no rsp_valid_o after release.
